// File: rtl/lsu_pkg.sv
// Shared load/store encodings, FSM states and store-lane helpers for the LSU and the main decoder.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b101;

  function automatic logic [3:0] store_wstrb(input logic [1:0] store, input logic [1:0] off);
    case (store)
      ST_SB:   return 4'b0001 << off;
      ST_SH:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] store, input logic [31:0] wd);
    case (store)
      ST_SB:   return {4{wd[7:0]}};
      ST_SH:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Byte accesses are always aligned; reserved encodings behave as word accesses.
  function automatic logic misaligned(input logic we, input logic [1:0] store,
                                      input logic [2:0] load, input logic [1:0] off);
    if (we) begin
      case (store)
        ST_SB:   return 1'b0;
        ST_SH:   return off[0];
        default: return off != 2'b00;
      endcase
    end
    case (load)
      LD_LB, LD_LBU: return 1'b0;
      LD_LH, LD_LHU: return off[0];
      default:       return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Single-outstanding data-memory bus: valid/ready request channel plus rvalid load response.
interface load_store_unit_if #(parameter int ADDR_W = 32) ();
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_wstrb;
  logic [31:0]       bus_wdata;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational byte/halfword extraction and sign/zero extension of a load response word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  load,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(rdata >> {off, 3'b000});
  assign half_sel = 16'(rdata >> {off[1], 4'b0000});

  always_comb begin
    data = rdata;
    case (load)
      LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LD_LH:   data = {{16{half_sel[15]}}, half_sel};
      LD_LBU:  data = {24'd0, byte_sel};
      LD_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle LSU: one bus transaction per access, store >= 2 cycles, load >= 3; stalls core via lsu_busy.
// Bus outputs hold while bus_ready is low. LSU_MISALIGN_TRAP_EN adds misalign_err and skips misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_req,
  input  logic              MemWrite,
  input  logic [1:0]        Store,
  input  logic [2:0]        Load,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              lsu_busy,
  output logic              lsu_done,
  load_store_unit_if.master bus
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              misalign_err
`endif
);

  lsu_state_t  state, state_nxt;
  logic        req_we;
  logic [2:0]  req_load;
  logic [1:0]  req_off;
  logic [31:0] load_data;
  logic        req_mis;

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_mis = misaligned(MemWrite, Store, Load, ALUResult[1:0]);
`else
  assign req_mis = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_req) state_nxt = req_mis ? DONE : REQ;
      REQ:  if (bus.bus_ready) state_nxt = req_we ? DONE : RSP;
      RSP:  if (bus.bus_rvalid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command is captured only in IDLE, so bus outputs stay frozen through any ready stall.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      req_we        <= 1'b0;
      req_load      <= LD_LW;
      req_off       <= 2'b00;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wstrb <= 4'b0000;
      bus.bus_wdata <= 32'd0;
      ReadData      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_err  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && mem_req) begin
        req_we        <= MemWrite;
        req_load      <= Load;
        req_off       <= ALUResult[1:0];
        bus.bus_we    <= MemWrite;
        bus.bus_addr  <= {ALUResult[ADDR_W-1:2], 2'b00};
        bus.bus_wstrb <= MemWrite ? store_wstrb(Store, ALUResult[1:0]) : 4'b0000;
        bus.bus_wdata <= MemWrite ? store_wdata(Store, WriteData) : 32'd0;
      end
      if (state == RSP && bus.bus_rvalid) ReadData <= load_data;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_err <= (state == IDLE) && mem_req && req_mis;
`endif
    end
  end

  lsu_load_align u_load_align (
    .rdata (bus.bus_rdata),
    .off   (req_off),
    .load  (req_load),
    .data  (load_data)
  );

  assign bus.bus_valid = (state == REQ);
  assign lsu_done      = (state == DONE);
  assign lsu_busy      = (state != IDLE) || mem_req;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized accesses checked against an arithmetic reference.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_req;
  logic        MemWrite;
  logic [1:0]  Store;
  logic [2:0]  Load;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        lsu_busy;
  logic        lsu_done;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_req      (mem_req),
    .MemWrite     (MemWrite),
    .Store        (Store),
    .Load         (Load),
    .ALUResult    (ALUResult),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .lsu_busy     (lsu_busy),
    .lsu_done     (lsu_done),
    .bus          (bus)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input int unsigned ld, input int unsigned addr,
                                           input int unsigned rd);
    int unsigned off = addr % 4;
    int unsigned b   = (rd >> (8 * off)) & 255;
    int unsigned h   = (rd >> (16 * (off / 2))) & 65535;
    case (ld)
      0:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      1:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3:       return b;
      5:       return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] ref_strb(input int unsigned st, input int unsigned addr);
    int unsigned off = addr % 4;
    if (st == 0) return 1 << off;
    if (st == 1) return (off >= 2) ? 12 : 3;
    return 15;
  endfunction

  function automatic logic [31:0] ref_wdata(input int unsigned st, input int unsigned wd);
    if (st == 0) return (wd & 255) * 32'h0101_0101;
    if (st == 1) return (wd & 65535) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic bit ref_mis(input bit we, input int unsigned st, input int unsigned ld,
                                 input int unsigned addr);
`ifdef LSU_MISALIGN_TRAP_EN
    int unsigned off = addr % 4;
    if (we) return (st == 0) ? 1'b0 : (st == 1) ? (off % 2 == 1) : (off != 0);
    if (ld == 0 || ld == 3) return 1'b0;
    if (ld == 1 || ld == 5) return off % 2 == 1;
    return off != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Entered just after a rising edge with the DUT idle; returns the same way.
  task automatic access(input bit we, input int unsigned st, input int unsigned ld,
                        input int unsigned addr, input int unsigned wd, input int unsigned rd,
                        input int rdy_dly, input int rv_dly);
    logic [31:0] e_addr  = addr & 32'hFFFF_FFFC;
    logic [31:0] e_strb  = we ? ref_strb(st, addr) : 32'd0;
    logic [31:0] e_wdata = we ? ref_wdata(st, wd) : 32'd0;
    bit          mis     = ref_mis(we, st, ld, addr);

    mem_req = 1'b1; MemWrite = we; Store = st[1:0]; Load = ld[2:0];
    ALUResult = addr; WriteData = wd;
    @(negedge clk);
    chk("busy_req", lsu_busy, 1);
    chk("valid_req", bus.bus_valid, 0);
    chk("done_idle", lsu_done, 0);
    @(posedge clk); #1;
    mem_req = 1'b0; MemWrite = $urandom_range(0, 1); Store = 2'($urandom);
    Load = 3'($urandom); ALUResult = $urandom; WriteData = $urandom;

    if (mis) begin
      @(negedge clk);
      chk("mis_done", lsu_done, 1);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_err", misalign_err, 1);
`endif
      chk("mis_valid", bus.bus_valid, 0);
      chk("mis_busy", lsu_busy, 1);
      chk("mis_rd_hold", ReadData, exp_rd);
      @(posedge clk); #1;
      return;
    end

    for (int k = 0; k <= rdy_dly; k++) begin
      bus.bus_ready  = (k == rdy_dly);
      bus.bus_rvalid = $urandom_range(0, 1);
      bus.bus_rdata  = $urandom;
      @(negedge clk);
      chk("req_valid", bus.bus_valid, 1);
      chk("req_we", bus.bus_we, {31'd0, we});
      chk("req_addr", bus.bus_addr, e_addr);
      chk("req_wstrb", {28'd0, bus.bus_wstrb}, e_strb);
      chk("req_wdata", bus.bus_wdata, e_wdata);
      chk("req_busy", lsu_busy, 1);
      chk("req_done", lsu_done, 0);
      @(posedge clk); #1;
    end
    bus.bus_ready  = 1'b0;
    bus.bus_rvalid = 1'b0;

    if (!we) begin
      for (int j = 1; j <= rv_dly; j++) begin
        bus.bus_rvalid = (j == rv_dly);
        bus.bus_rdata  = (j == rv_dly) ? rd : $urandom;
        @(negedge clk);
        chk("rsp_valid", bus.bus_valid, 0);
        chk("rsp_done", lsu_done, 0);
        chk("rsp_busy", lsu_busy, 1);
        @(posedge clk); #1;
      end
      bus.bus_rvalid = 1'b0;
      exp_rd = ref_load(ld, addr, rd);
    end

    @(negedge clk);
    chk("done_pulse", lsu_done, 1);
    chk("done_valid", bus.bus_valid, 0);
    chk("done_busy", lsu_busy, 1);
    chk("read_data", ReadData, exp_rd);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("done_err", misalign_err, 0);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; mem_req = 1'b0; MemWrite = 1'b0; Store = 2'b00; Load = 3'b000;
    ALUResult = 32'd0; WriteData = 32'd0;
    bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = 32'd0;
    exp_rd = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.bus_valid, 0);
    chk("rst_we", bus.bus_we, 0);
    chk("rst_addr", bus.bus_addr, 0);
    chk("rst_wstrb", {28'd0, bus.bus_wstrb}, 0);
    chk("rst_wdata", bus.bus_wdata, 0);
    chk("rst_rdata", ReadData, 0);
    chk("rst_done", lsu_done, 0);
    chk("rst_busy", lsu_busy, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("rst_err", misalign_err, 0);
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;

    access(1'b1, ST_SB, 0, 32'h1003, 32'h0000_00A5, 0, 0, 0);
    access(1'b0, 0, LD_LB, 32'h2001, 0, 32'h1234_80FF, 0, 2);
    chk("lb_value", ReadData, 32'hFFFF_FF80);
    access(1'b0, 0, LD_LBU, 32'h2001, 0, 32'h1234_80FF, 0, 2);
    chk("lbu_value", ReadData, 32'h0000_0080);
    access(1'b0, 0, LD_LHU, 32'h2002, 0, 32'h8001_0000, 1, 1);
    chk("lhu_value", ReadData, 32'h0000_8001);
    access(1'b0, 0, LD_LH, 32'h2002, 0, 32'h8001_0000, 0, 1);
    chk("lh_value", ReadData, 32'hFFFF_8001);
    access(1'b1, ST_SW, 0, 32'h3000, 32'hDEAD_BEEF, 0, 5, 0);
    access(1'b1, ST_SH, 0, 32'h3006, 32'h0000_1234, 0, 0, 0);
    access(1'b0, 0, LD_LW, 32'h3002, 0, 32'hCAFE_F00D, 0, 1);

    for (int i = 0; i < 80; i++)
      access(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 7),
             $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3));

    // Reset while a load waits for its response.
    mem_req = 1'b1; MemWrite = 1'b0; Load = LD_LW; ALUResult = 32'h4000;
    @(posedge clk); #1;
    mem_req = 1'b0; bus.bus_ready = 1'b1;
    @(posedge clk); #1;
    bus.bus_ready = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_rd = 32'd0;
    @(negedge clk);
    chk("rstrsp_valid", bus.bus_valid, 0);
    chk("rstrsp_done", lsu_done, 0);
    chk("rstrsp_busy", lsu_busy, 0);
    chk("rstrsp_rdata", ReadData, 0);
    @(posedge clk); #1;
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus.bus_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rv_done", lsu_done, 0);
    chk("late_rv_rdata", ReadData, 0);
    chk("late_rv_valid", bus.bus_valid, 0);
    @(posedge clk); #1;

    access(1'b0, 0, LD_LHU, 32'h5002, 0, 32'hBEEF_0000, 0, 1);
    access(1'b1, ST_SB, 0, 32'h5001, 32'h0000_003C, 0, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
